// File: rtl/pipe_pkg.sv
// ID/EX boundary types: field widths, payload bundle, NOP encodings.
// bubble() strips side effects from a payload the execute stage must ignore.
package pipe_pkg;

  localparam int INST_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int LSU_OP_W = 4;
  localparam int EXU_OP_W = 5;
  localparam int CSR_OP_W = 3;
  localparam int REG_W    = 5;

  localparam logic [LSU_OP_W-1:0] LSU_NOP = '0;
  localparam logic [CSR_OP_W-1:0] CSR_NOP = '0;
  localparam logic [EXU_OP_W-1:0] EXU_NOP = '0;

  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [ADDR_W-1:0]   pc;
    logic [DATA_W-1:0]   lsu_data;
    logic [DATA_W-1:0]   oprand1;
    logic [DATA_W-1:0]   oprand2;
    logic [EXU_OP_W-1:0] ex_op;
    logic [LSU_OP_W-1:0] lsu_op;
    logic [CSR_OP_W-1:0] csr_op;
    logic [REG_W-1:0]    rw_addr;
    logic                rw_en;
  } id_ex_payload_t;

  function automatic id_ex_payload_t bubble(input id_ex_payload_t p);
    id_ex_payload_t b;
    b        = p;
    b.rw_en  = 1'b0;
    b.lsu_op = LSU_NOP;
    b.csr_op = CSR_NOP;
    b.ex_op  = EXU_NOP;
    return b;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// Decode-stage bundle; the producer drives through o, consumers read through i.
// The same interface carries the registered bundle toward execute.
interface id_stage_if;
  import pipe_pkg::*;

  logic [INST_W-1:0]   inst;
  logic [ADDR_W-1:0]   pc;
  logic [DATA_W-1:0]   lsu_data;
  logic [DATA_W-1:0]   oprand1;
  logic [DATA_W-1:0]   oprand2;
  logic [EXU_OP_W-1:0] ex_op;
  logic [LSU_OP_W-1:0] lsu_op;
  logic [CSR_OP_W-1:0] csr_op;
  logic [REG_W-1:0]    rw_addr;
  logic                rw_en;

  modport i (
    input inst, pc, lsu_data, oprand1, oprand2,
    input ex_op, lsu_op, csr_op, rw_addr, rw_en
  );

  modport o (
    output inst, pc, lsu_data, oprand1, oprand2,
    output ex_op, lsu_op, csr_op, rw_addr, rw_en
  );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register slice with optional skid slot and flush.
// With the skid slot, o_ready comes straight from a flop.
module pipe_skid_buf #(
  parameter type T       = logic,
  parameter bit  SKID_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  if (SKID_EN) begin : g_skid
    logic r_main_v;
    logic r_skid_v;
    T     r_main;
    T     r_skid;
    logic w_acc;
    logic w_drn;

    assign o_ready = !r_skid_v;
    assign o_valid = r_main_v;
    assign o_data  = r_main;
    assign w_acc   = i_valid && !r_skid_v && !i_flush;
    assign w_drn   = r_main_v && i_ready;

    // skid content is always older than the word on i_data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
        r_main   <= '0;
        r_skid   <= '0;
      end else if (i_flush) begin
        r_main_v <= 1'b0;
        r_skid_v <= 1'b0;
      end else if (!r_main_v || w_drn) begin
        if (r_skid_v) begin
          r_main   <= r_skid;
          r_main_v <= 1'b1;
          r_skid_v <= 1'b0;
        end else if (w_acc) begin
          r_main   <= i_data;
          r_main_v <= 1'b1;
        end else begin
          r_main_v <= 1'b0;
        end
      end else if (w_acc) begin
        r_skid   <= i_data;
        r_skid_v <= 1'b1;
      end
    end
  end else begin : g_single
    logic r_main_v;
    T     r_main;
    logic w_acc;
    logic w_drn;

    assign o_ready = !r_main_v || i_ready;
    assign o_valid = r_main_v;
    assign o_data  = r_main;
    assign w_acc   = i_valid && o_ready && !i_flush;
    assign w_drn   = r_main_v && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_main_v <= 1'b0;
        r_main   <= '0;
      end else if (i_flush) begin
        r_main_v <= 1'b0;
      end else begin
        r_main_v <= w_acc || (r_main_v && !w_drn);
        if (w_acc) begin
          r_main <= i_data;
        end
      end
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX boundary register: elastic slice between decode and execute,
// bubble masking on invalid cycles and a saturating back-pressure counter.
module id_ex_pipe_reg
  import pipe_pkg::*;
#(
  parameter bit SKID_EN     = 1'b1,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   id_valid,
  output logic                   id_ready,
  id_stage_if.i                  id_in,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  id_stage_if.o                  ex_out,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  id_ex_payload_t        w_in;
  id_ex_payload_t        w_main;
  id_ex_payload_t        w_out;
  logic [STALL_CNT_W-1:0] r_stall;

  assign w_in.inst     = id_in.inst;
  assign w_in.pc       = id_in.pc;
  assign w_in.lsu_data = id_in.lsu_data;
  assign w_in.oprand1  = id_in.oprand1;
  assign w_in.oprand2  = id_in.oprand2;
  assign w_in.ex_op    = id_in.ex_op;
  assign w_in.lsu_op   = id_in.lsu_op;
  assign w_in.csr_op   = id_in.csr_op;
  assign w_in.rw_addr  = id_in.rw_addr;
  assign w_in.rw_en    = id_in.rw_en;

  pipe_skid_buf #(
    .T       (id_ex_payload_t),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_valid (id_valid),
    .o_ready (id_ready),
    .i_data  (w_in),
    .o_valid (ex_valid),
    .i_ready (ex_ready),
    .o_data  (w_main)
  );

  assign w_out = ex_valid ? w_main : bubble(w_main);

  assign ex_out.inst     = w_out.inst;
  assign ex_out.pc       = w_out.pc;
  assign ex_out.lsu_data = w_out.lsu_data;
  assign ex_out.oprand1  = w_out.oprand1;
  assign ex_out.oprand2  = w_out.oprand2;
  assign ex_out.ex_op    = w_out.ex_op;
  assign ex_out.lsu_op   = w_out.lsu_op;
  assign ex_out.csr_op   = w_out.csr_op;
  assign ex_out.rw_addr  = w_out.rw_addr;
  assign ex_out.rw_en    = w_out.rw_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (ex_valid && !ex_ready && (r_stall != '1)) begin
      r_stall <= r_stall + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall;

endmodule
